// File: rtl/stim_gen_pkg.sv
// Shared types and LFSR helper for the stream stimulus generator.
// Gate modes, FSM states and the Galois feedback polynomial live here.
package stim_gen_pkg;

   typedef enum logic [1:0] {
      GATE_PERIODIC = 2'd0,
      GATE_ALWAYS   = 2'd1,
      GATE_LFSR     = 2'd2,
      GATE_NEVER    = 2'd3
   } gate_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

endpackage

// File: rtl/stim_gate_gen.sv
// Traffic gate: window counter, free-running LFSR and mode select.
// The gate is a pure decode of registered state, so it is glitch-free per cycle.
module stim_gate_gen
   import stim_gen_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        advance,
   input  gate_mode_e  mode,
   input  logic [15:0] period,
   input  logic [15:0] on,
   output logic        gate
);

   logic [15:0] wcnt;
   logic [15:0] lfsr;
   logic [15:0] wlast;

   // A zero period behaves as a one-cycle window.
   assign wlast = (period == 16'd0) ? 16'd0 : period - 16'd1;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt <= '0;
         lfsr <= SEED;
      end else begin
         if (clear)
            wcnt <= '0;
         else if (advance)
            wcnt <= (wcnt >= wlast) ? '0 : wcnt + 16'd1;
         if (advance)
            lfsr <= lfsr_next(lfsr);
      end
   end

   // NOTE: the default before the case keeps this block free of inferred latches.
   always_comb begin
      gate = 1'b0;
      case (mode)
         GATE_PERIODIC: gate = (wcnt < on);
         GATE_ALWAYS:   gate = 1'b1;
         GATE_LFSR:     gate = (lfsr[7:0] < on[7:0]);
         GATE_NEVER:    gate = 1'b0;
         default:       gate = 1'b0;
      endcase
   end

endmodule

// File: rtl/stream_stim_gen.sv
// Stream stimulus source/sink: preloaded word memory streamed over valid/ready,
// independent sink ready pattern, frame counting and scale/bias lookup.
module stream_stim_gen
   import stim_gen_pkg::*;
#(
   parameter int          DATA_W    = 64,
   parameter int          DEPTH     = 50176,
   parameter int          ADDR_W    = $clog2(DEPTH),
   parameter int          CNT_W     = 32,
   parameter int          SB_DEPTH  = 384,
   parameter int          SB_AW     = 9,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [15:0]       cfg_period,
   input  logic [15:0]       cfg_on,
   input  logic [CNT_W-1:0]  cfg_total,
   input  logic [1:0]        cfg_m_mode,
   input  logic [1:0]        cfg_s_mode,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              s_last,
   input  logic              sb_we,
   input  logic [SB_AW-1:0]  sb_waddr,
   input  logic [15:0]       sb_wdata,
   input  logic [SB_AW-1:0]  scale_raddr,
   input  logic [SB_AW-1:0]  bias_raddr,
   output logic [7:0]        scale_out,
   output logic [7:0]        bias_out,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  in_count,
   output logic [CNT_W-1:0]  out_count,
   output logic [15:0]       frame_count
);

   state_e            state;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] mem    [DEPTH];
   logic [15:0]       sb_mem [SB_DEPTH];
   logic              m_gate, s_gate;
   logic              m_hs, s_hs, launch;
   logic [CNT_W:0]    in_next;

   assign launch  = start && (state != ST_RUN);
   assign m_hs    = m_valid && m_ready;
   assign s_hs    = s_valid && s_ready;
   assign in_next = {1'b0, in_count} + {{CNT_W{1'b0}}, m_hs};

   stim_gate_gen #(.SEED(LFSR_SEED)) u_m_gate (
      .clk     (clk),
      .reset   (reset),
      .clear   (launch),
      .advance (state == ST_RUN),
      .mode    (gate_mode_e'(cfg_m_mode)),
      .period  (cfg_period),
      .on      (cfg_on),
      .gate    (m_gate)
   );

   stim_gate_gen #(.SEED(~LFSR_SEED)) u_s_gate (
      .clk     (clk),
      .reset   (reset),
      .clear   (launch),
      .advance (state != ST_IDLE),
      .mode    (gate_mode_e'(cfg_s_mode)),
      .period  (cfg_period),
      .on      (cfg_on),
      .gate    (s_gate)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         m_valid     <= 1'b0;
         s_ready     <= 1'b0;
         in_count    <= '0;
         out_count   <= '0;
         frame_count <= '0;
         rd_addr     <= '0;
      end else begin
         s_ready <= (state != ST_IDLE) && s_gate;
         // A pending beat is held until accepted; the lookahead prevents overshoot.
         if (m_valid && !m_ready)
            m_valid <= 1'b1;
         else
            m_valid <= (state == ST_RUN) && m_gate && (in_next < {1'b0, cfg_total});

         if (launch) begin
            state       <= ST_RUN;
            in_count    <= '0;
            out_count   <= '0;
            frame_count <= '0;
            rd_addr     <= '0;
         end else begin
            if (state == ST_RUN && in_count >= cfg_total)
               state <= ST_DONE;
            if (m_hs) begin
               in_count <= in_next[CNT_W-1:0];
               rd_addr  <= (rd_addr == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr + ADDR_W'(1);
            end
            if (s_hs) begin
               if (s_last) begin
                  out_count   <= '0;
                  frame_count <= frame_count + 16'd1;
               end else begin
                  out_count <= out_count + CNT_W'(1);
               end
            end
         end
      end
   end

   assign busy   = (state == ST_RUN);
   assign done   = (state == ST_DONE);
   assign m_data = mem[rd_addr];

   // NOTE: the storage arrays are deliberately left out of reset so contents survive an abort.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= mem_wdata;
      if (sb_we)
         sb_mem[sb_waddr] <= sb_wdata;
   end

   // Reads see the array before this edge's write lands: read-old-data on collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         scale_out <= '0;
         bias_out  <= '0;
      end else begin
         scale_out <= sb_mem[scale_raddr][15:8];
         bias_out  <= sb_mem[bias_raddr][7:0];
      end
   end

endmodule

// File: tb/tb_stream_stim_gen.sv
// Self-checking bench for stream_stim_gen: randomized traffic against a
// cycle-level behavioural model, plus literal checks on the key scenarios.
module tb_stream_stim_gen;

   localparam int          DATA_W   = 64;
   localparam int          DEPTH    = 512;
   localparam int          ADDR_W   = $clog2(DEPTH);
   localparam int          CNT_W    = 32;
   localparam int          SB_DEPTH = 384;
   localparam int          SB_AW    = 9;
   localparam logic [15:0] SEED     = 16'hACE1;

   logic              clk;
   logic              reset, start;
   logic [15:0]       cfg_period, cfg_on;
   logic [CNT_W-1:0]  cfg_total;
   logic [1:0]        cfg_m_mode, cfg_s_mode;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              m_valid, m_ready;
   logic [DATA_W-1:0] m_data;
   logic              s_valid, s_ready, s_last;
   logic              sb_we;
   logic [SB_AW-1:0]  sb_waddr;
   logic [15:0]       sb_wdata;
   logic [SB_AW-1:0]  scale_raddr, bias_raddr;
   logic [7:0]        scale_out, bias_out;
   logic              busy, done;
   logic [CNT_W-1:0]  in_count, out_count;
   logic [15:0]       frame_count;

   int n_cmp = 0;
   int n_bad = 0;

   stream_stim_gen #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
      .SB_DEPTH(SB_DEPTH), .SB_AW(SB_AW), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .cfg_period(cfg_period), .cfg_on(cfg_on), .cfg_total(cfg_total),
      .cfg_m_mode(cfg_m_mode), .cfg_s_mode(cfg_s_mode),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
      .sb_we(sb_we), .sb_waddr(sb_waddr), .sb_wdata(sb_wdata),
      .scale_raddr(scale_raddr), .bias_raddr(bias_raddr),
      .scale_out(scale_out), .bias_out(bias_out),
      .busy(busy), .done(done),
      .in_count(in_count), .out_count(out_count), .frame_count(frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {P_IDLE, P_RUN, P_DONE} phase_t;
   phase_t            ph;
   longint            inc, outc, rc;
   int                frame;
   bit                mv, sr;
   logic [15:0]       ml, sl;
   logic [7:0]        sc, bi;
   logic [DATA_W-1:0] image [DEPTH];
   logic [15:0]       sbm   [SB_DEPTH];
   bit                model_on = 0;
   bit                img_ready = 0;
   bit                sb_ready = 0;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   // rc counts cycles since the run was launched; the window position is rc mod period.
   function automatic bit gate_open(input logic [1:0] mode, input longint cyc, input logic [15:0] l);
      longint p = (cfg_period == 16'd0) ? 1 : longint'(cfg_period);
      case (mode)
         2'd0:    return (cyc % p) < longint'(cfg_on);
         2'd1:    return 1'b1;
         2'd2:    return l[7:0] < cfg_on[7:0];
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         model_on = 1;
         ph = P_IDLE; inc = 0; outc = 0; frame = 0; rc = 0;
         mv = 0; sr = 0; ml = SEED; sl = ~SEED; sc = 0; bi = 0;
      end else if (model_on) begin
         bit hs, shs, mg, sg, nmv;
         hs  = mv && m_ready;
         shs = sr && s_valid;
         mg  = gate_open(cfg_m_mode, rc, ml);
         sg  = gate_open(cfg_s_mode, rc, sl);
         nmv = (mv && !m_ready) || (ph == P_RUN && mg && (inc + longint'(hs)) < longint'(cfg_total));
         sr  = (ph != P_IDLE) && sg;
         mv  = nmv;
         if (ph == P_RUN)  ml = lfsr_step(ml);
         if (ph != P_IDLE) sl = lfsr_step(sl);
         if (ph != P_RUN && start) begin
            ph = P_RUN; inc = 0; outc = 0; frame = 0; rc = 0;
         end else begin
            if (ph != P_IDLE) rc++;
            if (ph == P_RUN && inc >= longint'(cfg_total)) ph = P_DONE;
            if (hs) inc++;
            if (shs) begin
               if (s_last) begin outc = 0; frame++; end
               else outc++;
            end
         end
         sc = sbm[scale_raddr][15:8];
         bi = sbm[bias_raddr][7:0];
      end
      if (sb_we)  sbm[sb_waddr] = sb_wdata;
      if (mem_we) image[mem_waddr] = mem_wdata;
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("busy", busy, ph == P_RUN);
         check("done", done, ph == P_DONE);
         check("m_valid", m_valid, mv);
         check("s_ready", s_ready, sr);
         check("in_count", in_count, inc);
         check("out_count", out_count, outc);
         check("frame_count", frame_count, frame);
         if (img_ready) check("m_data", m_data, image[int'(inc % DEPTH)]);
         if (sb_ready) begin
            check("scale_out", scale_out, sc);
            check("bias_out", bias_out, bi);
         end
      end
   end

   // ---------------- monitors ----------------
   int  hs_cnt = 0, cur_burst = 0, max_burst = 0;
   int  sink_beat = 0, rdy_cyc = 0, tot_cyc = 0;
   bit  mv_seen = 0;
   int  mr_mode = 0;   // 0 low, 1 high, 2 toggle
   int  sv_mode = 0;   // 0 idle, 1 framed random, 2 always valid
   bit  sb_rand = 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (m_valid) mv_seen = 1;
         if (m_valid && m_ready) begin
            hs_cnt++;
            cur_burst++;
            if (cur_burst > max_burst) max_burst = cur_burst;
         end else begin
            cur_burst = 0;
         end
         if (sv_mode == 1 && sink_beat < 588) begin
            tot_cyc++;
            if (s_ready) rdy_cyc++;
         end
         if (s_valid && s_ready) sink_beat++;
      end
   end

   // ---------------- per-cycle random drivers ----------------
   always @(posedge clk) begin
      #2;
      case (mr_mode)
         1:       m_ready = 1'b1;
         2:       m_ready = ~m_ready;
         default: m_ready = 1'b0;
      endcase
      case (sv_mode)
         1: begin
            s_valid = (sink_beat < 588) && ($urandom_range(0, 3) != 0);
            s_last  = s_valid ? (sink_beat % 196 == 195) : 1'($urandom_range(0, 1));
         end
         2: begin
            s_valid = 1'b1;
            s_last  = 1'b0;
         end
         default: begin
            s_valid = 1'b0;
            s_last  = 1'($urandom_range(0, 1));
         end
      endcase
      if (sb_rand) begin
         scale_raddr = SB_AW'($urandom_range(0, SB_DEPTH - 1));
         bias_raddr  = SB_AW'($urandom_range(0, SB_DEPTH - 1));
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string name);
      int n = 0;
      while (done !== 1'b1 && n < bound) begin
         step();
         n++;
      end
      check({name, "_done_reached"}, done, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset = 1'b1; start = 1'b0;
      cfg_period = 16'd1; cfg_on = 16'd0; cfg_total = '0;
      cfg_m_mode = 2'd3; cfg_s_mode = 2'd3;
      mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      m_ready = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      sb_we = 1'b0; sb_waddr = '0; sb_wdata = '0;
      scale_raddr = '0; bias_raddr = '0;

      repeat (3) step();
      @(negedge clk);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_s_ready", s_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_in_count", in_count, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_scale", scale_out, 8'h00);
      check("rst_bias", bias_out, 8'h00);
      step();
      reset = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
         mem_we = 1'b1; mem_waddr = ADDR_W'(i); mem_wdata = {$urandom, $urandom};
         step();
      end
      mem_we = 1'b0;
      img_ready = 1;

      for (int i = 0; i < SB_DEPTH; i++) begin
         sb_we = 1'b1; sb_waddr = SB_AW'(i);
         sb_wdata = (i == 5) ? 16'h1234 : 16'($urandom);
         step();
      end
      sb_we = 1'b0;
      sb_ready = 1;

      // Same-address write and read: old data first, new data next cycle.
      sb_rand = 0;
      sb_we = 1'b1; sb_waddr = 9'd5; sb_wdata = 16'h7F80;
      scale_raddr = 9'd5; bias_raddr = 9'd5;
      step();
      sb_we = 1'b0;
      @(negedge clk);
      check("sb_collide_scale_old", scale_out, 8'h12);
      check("sb_collide_bias_old", bias_out, 8'h34);
      step();
      @(negedge clk);
      check("sb_scale5", scale_out, 8'h7F);
      check("sb_bias5", bias_out, 8'h80);
      sb_rand = 1;

      // total = 0: done two cycles after start, never valid.
      cfg_total = '0; cfg_m_mode = 2'd1; mr_mode = 1;
      step();
      mv_seen = 0;
      pulse_start();
      @(negedge clk);
      check("t0_busy", busy, 1'b1);
      check("t0_not_done", done, 1'b0);
      step();
      @(negedge clk);
      check("t0_done", done, 1'b1);
      repeat (3) step();
      check("t0_no_valid", mv_seen, 1'b0);

      // Periodic bursts with address wrap.
      cfg_period = 16'd37; cfg_on = 16'd8; cfg_total = 600; cfg_m_mode = 2'd0;
      hs_cnt = 0; max_burst = 0;
      pulse_start();
      wait_done(6000, "t1");
      repeat (3) step();
      @(negedge clk);
      check("t1_beats", hs_cnt, 600);
      check("t1_burst_le_on", max_burst <= 8, 1'b1);
      check("t1_in_count", in_count, 600);
      check("t1_wrap_data", m_data, image[88]);

      // Always-on source against a toggling ready.
      cfg_total = 10; cfg_m_mode = 2'd1; mr_mode = 2;
      hs_cnt = 0;
      pulse_start();
      wait_done(200, "t2");
      repeat (5) step();
      @(negedge clk);
      check("t2_beats", hs_cnt, 10);
      check("t2_in_count", in_count, 10);

      // LFSR sink, three frames of 196 beats.
      cfg_m_mode = 2'd3; cfg_s_mode = 2'd2; cfg_on = 16'd128; cfg_period = 16'd1;
      cfg_total = 1000; mr_mode = 1;
      sink_beat = 0; rdy_cyc = 0; tot_cyc = 0;
      pulse_start();
      sv_mode = 1;
      n = 0;
      while (frame_count !== 16'd3 && n < 10000) begin
         step();
         n++;
      end
      repeat (3) step();
      @(negedge clk);
      check("t4_frame_count", frame_count, 3);
      check("t4_out_count", out_count, 0);
      check("t4_duty_ok", (rdy_cyc * 100 >= tot_cyc * 35) && (rdy_cyc * 100 <= tot_cyc * 65), 1'b1);
      sv_mode = 0;

      // Abort at beat 100, then restart from the preserved memory.
      reset = 1'b1;
      step();
      reset = 1'b0;
      cfg_period = 16'd16; cfg_on = 16'd16; cfg_m_mode = 2'd0; cfg_s_mode = 2'd1;
      cfg_total = 400; mr_mode = 1; sv_mode = 2;
      hs_cnt = 0;
      pulse_start();
      n = 0;
      while (hs_cnt < 100 && n < 2000) begin
         step();
         n++;
      end
      check("t5_reached_100", hs_cnt, 100);
      reset = 1'b1;
      step();
      @(negedge clk);
      check("t5_abort_m_valid", m_valid, 1'b0);
      check("t5_abort_s_ready", s_ready, 1'b0);
      check("t5_abort_in_count", in_count, 0);
      check("t5_abort_out_count", out_count, 0);
      check("t5_abort_busy", busy, 1'b0);
      check("t5_abort_done", done, 1'b0);
      reset = 1'b0;
      sv_mode = 0; cfg_total = 50;
      hs_cnt = 0;
      pulse_start();
      wait_done(500, "t5_restart");
      repeat (2) step();
      @(negedge clk);
      check("t5_restart_beats", hs_cnt, 50);
      check("t5_restart_data", m_data, image[50]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stream_stim_gen.md
# stream_stim_gen

Synthesisable, parametrised stream stimulus source and sink for the systolic-array datapath. It replaces hand-written bench drivers in front of `Data_Generate` and similar blocks. It streams a preloaded word memory over a valid/ready master port under a programmable traffic pattern and accepts the DUT's output stream under an independent ready pattern. It also serves scale/bias lookups with one-cycle latency. Because it is synthesisable, the same block drives simulation and on-FPGA bring-up.

## Interface
Parameters:
- DATA_W, 64, master payload width (img2col input word)
- DEPTH, 50176, data memory words (224*224)
- ADDR_W, $clog2(DEPTH), data memory address width
- CNT_W, 32, beat counter width
- SB_DEPTH, 384, scale/bias entries
- SB_AW, 9, scale/bias address width
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; launches a run from IDLE or DONE
- cfg_period  in  16  traffic window length in cycles (0 treated as 1)
- cfg_on  in  16  cycles per window with gate open
- cfg_total  in  CNT_W  beats to send per run
- cfg_m_mode / cfg_s_mode  in  2 each  gate mode for master valid / sink ready: 0 periodic, 1 always, 2 LFSR, 3 never
- mem_we, mem_waddr[ADDR_W], mem_wdata[DATA_W]  in  data memory load port
- m_valid  out  1 ; m_ready  in  1 ; m_data  out  DATA_W  master stream to DUT
- s_valid  in  1 ; s_ready  out  1 ; s_last  in  1  DUT output stream
- sb_we, sb_waddr[SB_AW], sb_wdata[16]  in  scale/bias load; [15:8] scale, [7:0] bias
- scale_raddr, bias_raddr  in  SB_AW ; scale_out, bias_out  out  8
- busy, done  out  1 ; in_count, out_count  out  CNT_W ; frame_count  out  16

## Operation
- FSM states: IDLE → RUN on start. RUN → DONE when in_count reaches cfg_total. DONE → RUN on start. start in RUN is ignored.
- Entering RUN: clear in_count, out_count, frame_count, rd_addr and window counters. cfg_total==0 goes RUN → DONE next cycle with no m_valid.
- Window counter counts 0..cfg_period-1 and wraps. Periodic gate = wcnt < cfg_on, so cfg_on ≥ cfg_period means always open.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every RUN cycle. Gate = lfsr[7:0] < cfg_on[7:0].
- m_valid is registered. Next value = RUN && master gate && (in_count + hs) < cfg_total, where hs = m_valid&&m_ready. Overshoot past cfg_total is forbidden.
- Once m_valid is high it stays high and m_data stays stable until the handshake, regardless of the gate.
- m_data = mem[rd_addr] (asynchronous read). rd_addr increments on hs and wraps DEPTH-1 → 0.
- s_ready is registered: RUN or DONE, and sink gate. It is low in IDLE.
- out_count increments on s_valid&&s_ready.
- s_last with handshake: out_count → 0 and frame_count +1.
- s_last without handshake: ignored.
- busy = RUN. done = DONE (level).
- Scale/bias: scale_out ← sb_mem[scale_raddr][15:8] and bias_out ← sb_mem[bias_raddr][7:0], registered. A write and a read to the same address in the same cycle returns the old data.

## Timing
- Reset values: m_valid 0, s_ready 0, m_data = mem[0], scale_out/bias_out 0, counters 0, busy 0, done 0, state IDLE, lfsr LFSR_SEED.
- Reset mid-run aborts to IDLE next cycle. Memories are not cleared.
- start sampled at cycle t: busy=1 at t+1, earliest m_valid=1 at t+2.
- The last beat handshake at cycle k: in_count=cfg_total and m_valid=0 at k+1, done=1 at k+2.
- Scale/bias latency is 1 cycle.
- Memory load is only legal in IDLE or DONE. Writes during RUN are undefined.

## Structure
- Package stim_gen_pkg: gate mode enum, FSM state enum, LFSR tap constant.
- Sub-module stim_gate_gen: window counter, LFSR and mode mux, outputting gate. Instantiated twice (master, sink) with distinct seeds (LFSR_SEED, ~LFSR_SEED).
- Top: FSM, counters, data memory, scale/bias memory.

## Test plan
- Periodic, period=513, on=64, total=50176, m_ready=1 → exactly 50176 beats in bursts of ≤64. Data equals the memory image in order. done asserts; rd_addr wraps to 0.
- total=10, mode always, m_ready toggling every cycle → 10 handshakes, never 11. m_data stable across stalls.
- total=0 → done two cycles after start, m_valid never high.
- Sink: s_mode LFSR, on=128, DUT sends 3 frames of 196 beats with s_last → frame_count=3, out_count=0; s_ready duty ≈50%.
- Reset asserted at beat 100 mid-burst → next cycle m_valid=0, s_ready=0, counters 0, IDLE. Memory contents preserved on restart.
- Scale/bias entry 5 = 16'h7F80: read addr 5 → scale_out=8'h7F, bias_out=8'h80 one cycle later.
